chdr_framer: RTL

- Sits between a headerless sample generator (e.g. a file or pattern source) and the stream-source port of the NoC shell.
- Accepts a raw 64-bit sample stream and cuts it into fixed-length payloads.
- Emits each payload as a CHDR data packet: one header line (seqnum, byte length, SID), then the payload, then o_tlast.
- Buffers one full payload before sending its header, so a short final packet (burst end) still carries a correct length and the EOB flag.

---
 rtl/chdr_framer_pkg.sv | 26 ++
 rtl/chdr_framer_fifo.sv | 41 ++++
 rtl/chdr_framer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/chdr_framer_pkg.sv
// chdr_framer_pkg: shared types, CHDR header field offsets and settings offsets for chdr_framer
package chdr_framer_pkg;
  typedef enum logic [1:0] {IDLE, HEADER, TIME, PAYLOAD} state_t;
  localparam int HDR_TYPE = 62;
  localparam int HDR_HAS_TIME = 61;
  localparam int HDR_EOB = 60;
  localparam int HDR_SEQ = 48;
  localparam int HDR_LEN = 32;
  localparam int HDR_SID = 0;
  localparam logic [1:0] PKT_TYPE_DATA = 2'b00;
  localparam logic [7:0] SR_SID = 8'd0;
  localparam logic [7:0] SR_LEN = 8'd1;
  localparam logic [7:0] SR_EN = 8'd2;
  function automatic logic [63:0] chdr_hdr(input logic has_time, input logic eob, input logic [11:0] seq,
                                           input logic [15:0] len, input logic [31:0] sid);
    logic [63:0] h;
    h = '0;
    h[HDR_TYPE+:2] = PKT_TYPE_DATA;
    h[HDR_HAS_TIME] = has_time;
    h[HDR_EOB] = eob;
    h[HDR_SEQ+:12] = seq;
    h[HDR_LEN+:16] = len;
    h[HDR_SID+:32] = sid;
    return h;
  endfunction
endpackage

// File: rtl/chdr_framer_fifo.sv
// framer_fifo: payload buffer, 2^AW-line synchronous RAM plus a registered head-of-queue output
// Ports: clk/reset_n; wr/din push; rd pops the head; dout is the head line, valid while !empty;
// full reports the RAM full.
module framer_fifo #(
  parameter int AW = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr,
  input  logic [63:0] din,
  input  logic        rd,
  output logic [63:0] dout,
  output logic        full,
  output logic        empty
);
  logic [63:0] mem [0:(2**AW)-1];
  logic [AW-1:0] wp, rp;
  logic [AW:0] mc;
  logic qv, ld;
  // refill the head register whenever it is free or being popped
  assign ld = (mc != '0) && (!qv || rd);
  assign full = mc[AW];
  assign empty = !qv;
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
    if (ld) dout <= mem[rp];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      mc <= '0;
      qv <= 1'b0;
    end else begin
      wp <= wp + AW'(wr);
      rp <= rp + AW'(ld);
      mc <= mc + (AW+1)'(wr) - (AW+1)'(ld);
      qv <= ld || (qv && !rd);
    end
  end
endmodule

// File: rtl/chdr_framer.sv
// chdr_framer: cuts a raw 64-bit sample stream into fixed-length CHDR data packets
// Ports: clk, reset_n (async, active low); set_stb/set_addr/set_data settings bus
// (BASE+0 SID, BASE+1 LEN in lines, BASE+2 ENABLE); i_t* headerless sample input, i_tlast ends a
// burst and closes the packet with EOB; o_t* CHDR output (header, payload, o_tlast on last line).
// Macro CHDR_FRAMER_TIMESTAMP_EN adds vita_time and a timestamp line after each header.
module chdr_framer
  import chdr_framer_pkg::*;
#(
  parameter int BASE = 0,
  parameter int FIFO_SIZE = 9,
  parameter int DEFAULT_LEN = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
`ifdef CHDR_FRAMER_TIMESTAMP_EN
  input  logic [63:0] vita_time,
`endif
  input  logic [63:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [63:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready
);
  localparam logic [7:0] A_SID = 8'(BASE) + SR_SID;
  localparam logic [7:0] A_LEN = 8'(BASE) + SR_LEN;
  localparam logic [7:0] A_EN = 8'(BASE) + SR_EN;
  localparam logic [15:0] MAX_LEN = 16'(2 ** FIFO_SIZE);
`ifdef CHDR_FRAMER_TIMESTAMP_EN
  localparam logic HAS_T = 1'b1;
  localparam logic [15:0] HDR_BYTES = 16'd16;
`else
  localparam logic HAS_T = 1'b0;
  localparam logic [15:0] HDR_BYTES = 16'd8;
`endif
  logic [31:0] sid_r, sid_l, sid_c, pend_sid;
  logic [15:0] len_r, len_l, len_e, len_c, cnt, pend_lines, k, nk;
  logic en_r, first, close, acc, pend_full, pend_eob, pend_clr, pop, f_full, f_empty;
  logic [63:0] f_q, t_word;
  logic [11:0] seq;
  state_t state;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sid_r <= '0;
      len_r <= 16'(DEFAULT_LEN);
      en_r <= 1'b0;
    end else if (set_stb) begin
      if (set_addr == A_SID) sid_r <= set_data;
      if (set_addr == A_LEN) len_r <= set_data[15:0];
      if (set_addr == A_EN) en_r <= set_data[0];
    end
  end
  // settings are taken live only on the first line of a packet, latched copies afterwards
  assign len_e = (len_r == 16'd0) ? 16'd1 : (len_r > MAX_LEN) ? MAX_LEN : len_r;
  assign first = cnt == 16'd0;
  assign len_c = first ? len_e : len_l;
  assign sid_c = first ? sid_r : sid_l;
  assign close = i_tlast || (cnt + 16'd1 == len_c);
  assign i_tready = (first ? en_r : 1'b1) && !f_full && !(close && pend_full);
  assign acc = i_tvalid && i_tready;
`ifdef CHDR_FRAMER_TIMESTAMP_EN
  logic [63:0] time_l, time_c, pend_time;
  assign time_c = first ? vita_time : time_l;
  assign t_word = pend_time;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      time_l <= '0;
      pend_time <= '0;
    end else if (acc) begin
      if (first) time_l <= vita_time;
      if (close) pend_time <= time_c;
    end
  end
`else
  assign t_word = '0;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      len_l <= '0;
      sid_l <= '0;
      pend_lines <= '0;
      pend_eob <= 1'b0;
      pend_sid <= '0;
      pend_full <= 1'b0;
    end else begin
      if (acc) begin
        cnt <= close ? 16'd0 : cnt + 16'd1;
        if (first) begin
          len_l <= len_e;
          sid_l <= sid_r;
        end
        if (close) begin
          pend_lines <= cnt + 16'd1;
          pend_eob <= i_tlast;
          pend_sid <= sid_c;
        end
      end
      // slot may be released and refilled on the same edge
      pend_full <= (acc && close) || (pend_full && !pend_clr);
    end
  end
  assign pend_clr = state == PAYLOAD && o_tready && o_tlast;
  assign nk = state == PAYLOAD ? k + 16'd1 : 16'd1;
  assign pop = o_tready && !f_empty &&
               (state == TIME || (state == HEADER && !HAS_T) || (state == PAYLOAD && !o_tlast));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      o_tdata <= '0;
      o_tlast <= 1'b0;
      o_tvalid <= 1'b0;
      seq <= '0;
      k <= '0;
    end else if (state == IDLE) begin
      if (pend_full) begin
        o_tdata <= chdr_hdr(HAS_T, pend_eob, seq, HDR_BYTES + {pend_lines[12:0], 3'b000}, pend_sid);
        o_tvalid <= 1'b1;
        o_tlast <= 1'b0;
        state <= HEADER;
      end
    end else if (o_tready && state == HEADER && HAS_T) begin
      o_tdata <= t_word;
      state <= TIME;
    end else if (pop) begin
      o_tdata <= f_q;
      o_tlast <= nk == pend_lines;
      k <= nk;
      state <= PAYLOAD;
    end else if (pend_clr) begin
      o_tvalid <= 1'b0;
      o_tlast <= 1'b0;
      seq <= seq + 12'd1;
      state <= IDLE;
    end
  end
  framer_fifo #(.AW(FIFO_SIZE)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .wr(acc),
    .din(i_tdata),
    .rd(pop),
    .dout(f_q),
    .full(f_full),
    .empty(f_empty)
  );
endmodule
